// File: rtl/stack_frame_reverser.sv
// Frame reverser driving an external push/pop LIFO: pushes each input byte,
// waits for the stack write latency, then pops the frame back out in reverse.
module stack_frame_reverser #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 32,
  parameter int SETTLE = 2
) (
  input  logic             m_clock,
  input  logic             p_reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             stk_push,
  output logic [WIDTH-1:0] stk_din,
  output logic             stk_pop,
  input  logic [WIDTH-1:0] stk_dout,
  input  logic             stk_empty,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_SETTLE,
    ST_DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    set_q, set_d;
  logic             drop_q, drop_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] odata_q, odata_d;
  logic             ovld_q, ovld_d;
  logic             olast_q, olast_d;
  logic [1:0]       ewait_q;

  assign stk_din   = in_data;
  assign out_data  = odata_q;
  assign out_valid = ovld_q;
  assign out_last  = olast_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q == ST_SETTLE) || (state_q == ST_DRAIN);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    set_d    = set_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    odata_d  = odata_q;
    ovld_d   = ovld_q;
    olast_d  = olast_q;
    in_ready = 1'b0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    case (state_q)
      ST_FILL: begin
        // After a truncated frame, swallow its tail until in_last.
        in_ready = drop_q || (cnt_q < CNT_MAX);
        if (in_valid && in_ready) begin
          if (drop_q) begin
            if (in_last) drop_d = 1'b0;
          end else begin
            stk_push = 1'b1;
            cnt_d    = cnt_q + 1'b1;
            if (in_last) begin
              state_d = ST_SETTLE;
              set_d   = '0;
            end else if (cnt_q == CNT_MAX - 1'b1) begin
              ovf_d   = 1'b1;
              drop_d  = 1'b1;
              state_d = ST_SETTLE;
              set_d   = '0;
            end
          end
        end
      end
      ST_SETTLE: begin
        if (set_q == SET_LAST) state_d = ST_DRAIN;
        else                   set_d   = set_q + 1'b1;
      end
      ST_DRAIN: begin
        if (ovld_q && out_ready) ovld_d = 1'b0;
        if ((cnt_q != '0) && (!ovld_q || out_ready)) begin
          stk_pop = 1'b1;
          odata_d = stk_dout;
          ovld_d  = 1'b1;
          olast_d = (cnt_q == CW'(1));
          cnt_d   = cnt_q - 1'b1;
        end else if (ovld_q && out_ready && olast_q) begin
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
      set_q   <= '0;
      drop_q  <= 1'b0;
      ovf_q   <= 1'b0;
      odata_q <= '0;
      ovld_q  <= 1'b0;
      olast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      set_q   <= set_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      odata_q <= odata_d;
      ovld_q  <= ovld_d;
      olast_q <= olast_d;
    end
  end

  // Consecutive cycles spent idle-and-empty while the stack still reports data.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      ewait_q <= '0;
    end else if (state_q == ST_FILL && cnt_q == '0 && !stk_empty) begin
      ewait_q <= (ewait_q == 2'd2) ? 2'd2 : ewait_q + 2'd1;
    end else begin
      ewait_q <= '0;
    end
  end

  a_no_push_and_pop: assert property (@(posedge m_clock) disable iff (!p_reset)
    !(stk_push && stk_pop));
  a_no_pop_when_empty: assert property (@(posedge m_clock) disable iff (!p_reset)
    stk_pop |-> (cnt_q != '0));
  a_stack_empties: assert property (@(posedge m_clock) disable iff (!p_reset)
    !(state_q == ST_FILL && cnt_q == '0 && !stk_empty && ewait_q == 2'd2));

endmodule
